gene_stream_loader: RTL and testbench

- Upstream feeder for PE_array.
- Accepts a byte-free 2-bit base stream over a valid/ready handshake.
- Packs the first LEN bases (gene 2) into the parallel reference bus o_B, and buffers the next LEN bases (gene 1).
- Replays the buffered gene 1 one base per cycle with o_start high, then waits a drain window for the array and pulses o_done.

---
 rtl/gene_stream_loader.sv | 157 +++++++++++++++
 tb/tb_gene_stream_loader.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gene_stream_loader.sv
// Streams a gene pair into PE_array: gene 2 is packed onto o_B, gene 1
// is buffered and replayed one base per cycle, then a drain window ends in o_done.
module gene_stream_loader #(
    parameter int LEN   = 64,
    parameter int DRAIN = 128
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic             i_in_valid,
    input  logic [1:0]       i_in_data,
    output logic             o_in_ready,
    output logic [2*LEN-1:0] o_B,
    output logic [1:0]       o_A,
    output logic             o_start,
    output logic             o_busy,
    output logic             o_done
);
    localparam int MAXC = (LEN > DRAIN) ? LEN : DRAIN;
    localparam int CW   = $clog2(MAXC) + 1;
    localparam int AW   = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CW-1:0] LEN_LAST   = CW'(LEN - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_B,
        LOAD_A,
        STREAM,
        DRAIN_W,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2*LEN-1:0] b_q, b_d;
    logic [1:0]       a_q, a_d;
    logic             start_q, start_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [1:0]       buf_q [LEN];
    logic             buf_we;
    logic [AW-1:0]    idx, idx_nxt;
    logic             xfer, last;

    assign idx     = cnt_q[AW-1:0];
    assign idx_nxt = idx + AW'(1);
    assign xfer    = i_in_valid && ready_q;
    assign last    = (cnt_q == LEN_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        b_d     = b_q;
        a_d     = 2'b00;
        start_d = 1'b0;
        buf_we  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_load) begin
                    state_d = LOAD_B;
                    cnt_d   = '0;
                end
            end
            LOAD_B: begin
                if (xfer) begin
                    b_d[{idx, 1'b0} +: 2] = i_in_data;
                    if (last) begin
                        state_d = LOAD_A;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            LOAD_A: begin
                if (xfer) begin
                    buf_we = 1'b1;
                    if (last) begin
                        state_d = STREAM;
                        cnt_d   = '0;
                        start_d = 1'b1;
                        // base 0 is only being written now when LEN is 1
                        a_d     = (idx == '0) ? i_in_data : buf_q[0];
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            STREAM: begin
                if (last) begin
                    state_d = DRAIN_W;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    start_d = 1'b1;
                    a_d     = buf_q[idx_nxt];
                end
            end
            DRAIN_W: begin
                if (cnt_q == DRAIN_LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        ready_d = (state_d == LOAD_B) || (state_d == LOAD_A);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            b_q     <= '0;
            a_q     <= 2'b00;
            start_q <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            b_q     <= b_d;
            a_q     <= a_d;
            start_q <= start_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (buf_we) begin
            buf_q[idx] <= i_in_data;
        end
    end

    assign o_in_ready = ready_q;
    assign o_B        = b_q;
    assign o_A        = a_q;
    assign o_start    = start_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;

endmodule

// File: tb/tb_gene_stream_loader.sv
// Randomized bench for gene_stream_loader against a transfer-count model,
// plus a small LEN=4/DRAIN=3 instance with literal expectations.
module tb_gene_stream_loader;
    localparam int LEN   = 64;
    localparam int DRAIN = 128;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_load, in_valid;
    logic [1:0]       in_data;
    logic             o_in_ready, o_start, o_busy, o_done;
    logic [2*LEN-1:0] o_B;
    logic [1:0]       o_A;

    logic       s_load, s_valid;
    logic [1:0] s_data;
    logic       s_ready, s_start, s_busy, s_done;
    logic [7:0] s_B;
    logic [1:0] s_A;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    // model: run flag, bases accepted this run, cycles since last accepted base
    bit         run;
    int         n, t;
    logic [1:0] mb [LEN];
    logic [1:0] ma [LEN];

    always #5 clk = ~clk;

    gene_stream_loader #(.LEN(LEN), .DRAIN(DRAIN)) u_dut (
        .i_clk(clk), .i_rst(rst_n), .i_load(in_load),
        .i_in_valid(in_valid), .i_in_data(in_data),
        .o_in_ready(o_in_ready), .o_B(o_B), .o_A(o_A),
        .o_start(o_start), .o_busy(o_busy), .o_done(o_done)
    );

    gene_stream_loader #(.LEN(4), .DRAIN(3)) u_small (
        .i_clk(clk), .i_rst(rst_n), .i_load(s_load),
        .i_in_valid(s_valid), .i_in_data(s_data),
        .o_in_ready(s_ready), .o_B(s_B), .o_A(s_A),
        .o_start(s_start), .o_busy(s_busy), .o_done(s_done)
    );

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [2*LEN-1:0] pack_b();
        logic [2*LEN-1:0] r;
        for (int k = 0; k < LEN; k++) r[2*k +: 2] = mb[k];
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run <= 1'b0;
            n   <= 0;
            t   <= 0;
            for (int k = 0; k < LEN; k++) mb[k] <= 2'b00;
        end else if (!run) begin
            if (in_load) begin
                run <= 1'b1;
                n   <= 0;
                t   <= 0;
            end
        end else if (n < 2*LEN) begin
            if (in_valid) begin
                if (n < LEN) mb[n] <= in_data;
                else         ma[n-LEN] <= in_data;
                n <= n + 1;
                t <= 0;
            end
        end else if (t == LEN + DRAIN) begin
            run <= 1'b0;
        end else begin
            t <= t + 1;
        end
    end

    always @(negedge clk) begin : cmp
        bit         es;
        logic [1:0] ea;
        if (chk_on) begin
            es = run && (n == 2*LEN) && (t < LEN);
            ea = es ? ma[t] : 2'b00;
            chk("ready", 128'(o_in_ready), 128'(run && (n < 2*LEN)));
            chk("busy",  128'(o_busy),     128'(run));
            chk("start", 128'(o_start),    128'(es));
            chk("A",     128'(o_A),        128'(ea));
            chk("done",  128'(o_done),
                128'(run && (n == 2*LEN) && (t == LEN + DRAIN)));
            chk("B",     128'(o_B),        128'(pack_b()));
        end
    end

    task automatic do_load();
        in_load = 1'b1;
        @(posedge clk); #1;
        in_load = 1'b0;
    endtask

    // mode 0: back-to-back, 1: valid pattern 1,0,0,1, 2: random valid and data
    task automatic feed(input int mode, input bit inj);
        int i = 0;
        int c = 0;
        while (i < 2*LEN && c < 20*LEN) begin
            bit v;
            case (mode)
                0:       v = 1'b1;
                1:       v = (c % 4 == 0) || (c % 4 == 3);
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            in_valid = v;
            in_data  = (mode < 2) ? 2'(i % 4) : 2'($urandom);
            in_load  = inj && (i == LEN + 5);
            @(posedge clk); #1;
            if (v) i++;
            c++;
        end
        in_valid = 1'b0;
        in_load  = 1'b0;
        in_data  = 2'b00;
        chk("feed_complete", 128'(i), 128'(2*LEN));
    endtask

    task automatic wait_done(input bit lit, input bit inj);
        int k    = 0;
        int st   = 0;
        int last = -1;
        bit seen = 1'b0;
        while (k < LEN + DRAIN + 50) begin
            @(negedge clk);
            if (inj) begin
                in_valid = (k < LEN);
                in_data  = 2'($urandom);
                in_load  = (k >= 3 && k <= 5);
            end
            if (o_start) begin
                if (lit) chk("A_lit", 128'(o_A), 128'(st % 4));
                st++;
                last = k;
            end
            if (o_done) begin
                seen = 1'b1;
                break;
            end
            k++;
        end
        in_valid = 1'b0;
        in_load  = 1'b0;
        chk("done_seen", 128'(seen), 128'(1));
        chk("start_len", 128'(st), 128'(LEN));
        chk("done_gap", 128'(k - last), 128'(DRAIN + 1));
    endtask

    initial begin
        int         sdat [8] = '{3, 2, 1, 0, 1, 3, 0, 2};
        int         sexp [4] = '{1, 3, 0, 2};
        logic [1:0] sa   [4];
        int         k, st, last;
        bit         seen;

        rst_n = 1'b0; in_load = 1'b0; in_valid = 1'b0; in_data = 2'b00;
        s_load = 1'b0; s_valid = 1'b0; s_data = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_B", 128'(o_B), 128'(0));
        chk("rst_start", 128'(o_start), 128'(0));
        chk("rst_busy", 128'(o_busy), 128'(0));
        chk("rst_ready", 128'(o_in_ready), 128'(0));
        chk("rst_done", 128'(o_done), 128'(0));
        rst_n  = 1'b1;
        chk_on = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        do_load();
        feed(0, 1'b0);
        chk("B_nominal", 128'(o_B), {16{8'hE4}});
        wait_done(1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        do_load();
        feed(1, 1'b0);
        chk("B_stall", 128'(o_B), {16{8'hE4}});
        wait_done(1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        do_load();
        feed(2, 1'b1);
        wait_done(1'b0, 1'b1);

        in_load = 1'b1;
        @(posedge clk); #1;
        chk("b2b_ignored", 128'(o_busy), 128'(0));
        @(posedge clk); #1;
        in_load = 1'b0;
        chk("b2b_accepted", 128'(o_in_ready), 128'(1));
        feed(2, 1'b0);
        wait_done(1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        do_load();
        feed(2, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_start", 128'(o_start), 128'(0));
        chk("mid_rst_A", 128'(o_A), 128'(0));
        chk("mid_rst_B", 128'(o_B), 128'(0));
        chk("mid_rst_busy", 128'(o_busy), 128'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 2'($urandom);
            @(posedge clk); #1;
            chk("post_rst_ready", 128'(o_in_ready), 128'(0));
            chk("post_rst_busy", 128'(o_busy), 128'(0));
        end
        in_valid = 1'b0;
        do_load();
        feed(2, 1'b0);
        wait_done(1'b0, 1'b0);

        s_load = 1'b1;
        @(posedge clk); #1;
        s_load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s_valid = 1'b1;
            s_data  = 2'(sdat[i]);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        chk("s_B", 128'(s_B), 128'(8'h1B));
        k = 0; st = 0; last = -1; seen = 1'b0;
        while (k < 40) begin
            @(negedge clk);
            if (s_start) begin
                if (st < 4) sa[st] = s_A;
                st++;
                last = k;
            end
            if (s_done) begin
                seen = 1'b1;
                break;
            end
            k++;
        end
        chk("s_done_seen", 128'(seen), 128'(1));
        chk("s_start_len", 128'(st), 128'(4));
        for (int i = 0; i < 4; i++) chk("s_A", 128'(sa[i]), 128'(sexp[i]));
        chk("s_done_gap", 128'(k - last), 128'(4));
        @(negedge clk);
        chk("s_done_pulse", 128'(s_done), 128'(0));
        chk("s_idle", 128'(s_busy), 128'(0));

        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
